// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage constants and FSM state encoding.
package if_fetch_ctrl_pkg;

    localparam int unsigned PC_LENGTH = 32;
    localparam int unsigned PC_STEP   = 4;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;

    typedef enum logic [1:0] {
        IF_ST_IDLE  = 2'd0,
        IF_ST_FETCH = 2'd1,
        IF_ST_HOLD  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch_ctrl_redirect_latch.sv
// Holds one redirect target that arrived while InstMem was still busy.
module if_redirect_latch #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set,
    input  logic [W-1:0] set_target,
    input  logic         clr,
    output logic         valid,
    output logic [W-1:0] target
);
    import if_fetch_ctrl_pkg::*;

    // A newer redirect always replaces an older one; set beats clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= DISABLE;
            target <= '0;
        end else if (set) begin
            valid  <= ENABLE;
            target <= set_target;
        end else if (clr) begin
            valid  <= DISABLE;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: PC register, next-PC selection and InstMem sequencing.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned           PC_LENGTH = if_fetch_ctrl_pkg::PC_LENGTH,
    parameter int unsigned           PC_STEP   = if_fetch_ctrl_pkg::PC_STEP,
    parameter logic [PC_LENGTH-1:0]  RESET_PC  = PC_LENGTH'('hFC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 branch_valid_i,
    input  logic [PC_LENGTH-1:0] branch_target_i,
    input  logic                 jump_valid_i,
    input  logic [PC_LENGTH-1:0] jump_target_i,
    input  logic                 rom_ready_i,
    output logic [PC_LENGTH-1:0] pc_o,
    output logic                 rom_ce_o,
    output logic                 inst_valid_o,
    output logic                 flush_o
);
    localparam logic [PC_LENGTH-1:0] STEP = PC_LENGTH'(PC_STEP);

    if_state_e            state;
    logic                 pend_valid;
    logic [PC_LENGTH-1:0] pend_target;
    logic                 new_redirect;
    logic                 redirect;
    logic [PC_LENGTH-1:0] new_target;
    logic [PC_LENGTH-1:0] redirect_target;
    logic                 pend_set;
    logic                 pend_clr;

    assign new_redirect    = branch_valid_i | jump_valid_i;
    assign redirect        = new_redirect | pend_valid;
    assign new_target      = branch_valid_i ? branch_target_i : jump_target_i;
    assign redirect_target = new_redirect ? new_target : pend_target;

    assign pend_set = (state == IF_ST_FETCH) & ~rom_ready_i & new_redirect;
    assign pend_clr = (state == IF_ST_FETCH) & rom_ready_i;

    if_redirect_latch #(.W(PC_LENGTH)) u_redirect_latch (
        .clk        (clk),
        .rst        (rst),
        .set        (pend_set),
        .set_target (new_target),
        .clr        (pend_clr),
        .valid      (pend_valid),
        .target     (pend_target)
    );

    assign inst_valid_o = (state == IF_ST_FETCH) & rom_ready_i & ~stall_i & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IF_ST_IDLE;
            pc_o     <= RESET_PC;
            rom_ce_o <= DISABLE;
            flush_o  <= DISABLE;
        end else begin
            flush_o <= DISABLE;
            case (state)
                IF_ST_IDLE: begin
                    state    <= IF_ST_FETCH;
                    pc_o     <= RESET_PC + STEP;
                    rom_ce_o <= ENABLE;
                end
                IF_ST_FETCH: begin
                    // Redirects seen during a wait are parked in the latch, but still flush now.
                    flush_o <= new_redirect;
                    if (rom_ready_i) begin
                        if (redirect)
                            pc_o <= redirect_target;
                        else if (stall_i)
                            state <= IF_ST_HOLD;
                        else
                            pc_o <= pc_o + STEP;
                    end
                end
                IF_ST_HOLD: begin
                    flush_o <= new_redirect;
                    if (new_redirect) begin
                        pc_o  <= new_target;
                        state <= IF_ST_FETCH;
                    end else if (!stall_i) begin
                        state <= IF_ST_FETCH;
                    end
                end
                default: state <= IF_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed + random bench for if_fetch_ctrl against a cycle-level reference model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_A = 32'h0000_00FC;
    localparam logic [31:0] RST_B = 32'hFFFF_FFF8;
    localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst, stall, bv, jv, ready;
    logic [31:0] bt, jt;
    logic [31:0] pc_a, pc_b;
    logic        ce_a, ce_b, iv_a, iv_b, fl_a, fl_b;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = DUT A, 1 = DUT B
    logic [31:0] m_rpc[2];
    logic [31:0] m_pc[2];
    int          m_mode[2];
    bit          m_ce[2], m_fl[2];
    logic [31:0] m_pend[2][$];

    always #5 clk = ~clk;

    if_fetch_ctrl #(.RESET_PC(RST_A)) dut_a (
        .clk(clk), .rst(rst), .stall_i(stall),
        .branch_valid_i(bv), .branch_target_i(bt),
        .jump_valid_i(jv), .jump_target_i(jt),
        .rom_ready_i(ready),
        .pc_o(pc_a), .rom_ce_o(ce_a), .inst_valid_o(iv_a), .flush_o(fl_a)
    );

    if_fetch_ctrl #(.RESET_PC(RST_B)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall),
        .branch_valid_i(bv), .branch_target_i(bt),
        .jump_valid_i(jv), .jump_target_i(jt),
        .rom_ready_i(ready),
        .pc_o(pc_b), .rom_ce_o(ce_b), .inst_valid_o(iv_b), .flush_o(fl_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = m_rpc[k]; m_mode[k] = M_IDLE; m_ce[k] = 0; m_fl[k] = 0;
                m_pend[k].delete();
            end else begin
                m_fl[k] = (m_mode[k] != M_IDLE) && (bv || jv);
                case (m_mode[k])
                    M_IDLE: begin
                        m_mode[k] = M_FETCH; m_pc[k] = m_rpc[k] + 32'd4; m_ce[k] = 1;
                    end
                    M_FETCH: begin
                        if (ready) begin
                            if (bv)                          m_pc[k] = bt;
                            else if (jv)                     m_pc[k] = jt;
                            else if (m_pend[k].size() != 0)  m_pc[k] = m_pend[k][0];
                            else if (stall)                  m_mode[k] = M_HOLD;
                            else                             m_pc[k] = m_pc[k] + 32'd4;
                            m_pend[k].delete();
                        end else if (bv || jv) begin
                            m_pend[k].delete();
                            m_pend[k].push_back(bv ? bt : jt);
                        end
                    end
                    default: begin
                        if (bv || jv) begin
                            m_pc[k] = bv ? bt : jt; m_mode[k] = M_FETCH;
                        end else if (!stall) begin
                            m_mode[k] = M_FETCH;
                        end
                    end
                endcase
            end
        end
    endtask

    // Apply inputs (at negedge), then compare every output of both DUTs with the model.
    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] btv,
                         input logic j, input logic [31:0] jtv, input logic rdy);
        bit exp_iv;
        rst = r; stall = s; bv = b; bt = btv; jv = j; jt = jtv; ready = rdy;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_iv = (m_mode[k] == M_FETCH) && ready && !stall && !(bv || jv || m_pend[k].size() != 0);
            chk($sformatf("pc%0d", k),    k ? pc_b : pc_a, m_pc[k]);
            chk($sformatf("ce%0d", k),    32'(k ? ce_b : ce_a), 32'(m_ce[k]));
            chk($sformatf("flush%0d", k), 32'(k ? fl_b : fl_a), 32'(m_fl[k]));
            chk($sformatf("ivld%0d", k),  32'(k ? iv_b : iv_a), 32'(exp_iv));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        m_rpc[0] = RST_A; m_rpc[1] = RST_B;
        rst = 1; stall = 0; bv = 0; jv = 0; ready = 1; bt = '0; jt = '0;
        @(negedge clk);
        tick();

        // Reset for 3 cycles, then run sequentially
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1); chk("rst_pc", pc_a, 32'hFC); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1); chk("idle_pc", pc_a, 32'hFC); chk("idle_ce", 32'(ce_a), 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("first_pc", pc_a, 32'h100); chk("first_ce", 32'(ce_a), 1);
        chk("wrap_first", pc_b, 32'hFFFF_FFFC); tick();
        drive(0, 0, 0, 0, 0, 0, 0); chk("pc_104", pc_a, 32'h104); chk("wrap_zero", pc_b, 32'h0); tick();

        // Wait states at 0x104
        drive(0, 0, 0, 0, 0, 0, 0); chk("wait_pc", pc_a, 32'h104); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("ready_iv", 32'(iv_a), 1); tick();

        // Stall at 0x108 for 2 cycles, then release
        drive(0, 1, 0, 0, 0, 0, 1); chk("pc_108", pc_a, 32'h108); chk("stall_iv", 32'(iv_a), 0); tick();
        drive(0, 1, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("hold_pc", pc_a, 32'h108); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("refetch_iv", 32'(iv_a), 1); tick();

        // Branch to 0x200 while InstMem waits
        drive(0, 0, 1, 32'h200, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); chk("br_flush", 32'(fl_a), 1); chk("br_hold", pc_a, 32'h10C); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("pend_iv", 32'(iv_a), 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("br_pc", pc_a, 32'h200); tick();

        // Simultaneous branch and jump: branch wins
        drive(0, 0, 1, 32'h300, 1, 32'h400, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("prio_pc", pc_a, 32'h300); chk("prio_flush", 32'(fl_a), 1); tick();

        // Reset mid-fetch with a pending jump
        drive(0, 0, 0, 0, 1, 32'h500, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("mid_rst_pc", pc_a, 32'hFC); chk("mid_rst_ce", 32'(ce_a), 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1); chk("pend_dropped", pc_a, 32'h100); tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), $urandom(),
                  ($urandom_range(0, 7) == 0), $urandom(),
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
